// File: rtl/sync_level_fifo_if.sv
// Handshake and status bundle for sync_level_fifo.
// slave = FIFO side, master = producer/consumer side.
interface sync_level_fifo_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 4
);
   logic                   Clear_in;
   logic [DATA_WIDTH-1:0]  Data_in;
   logic                   WriteEn_in;
   logic                   Full_out;
   logic                   AlmostFull_out;
   logic                   ReadEn_in;
   logic [DATA_WIDTH-1:0]  Data_out;
   logic                   Empty_out;
   logic                   AlmostEmpty_out;
   logic [ADDRESS_WIDTH:0] Level_out;
   logic                   Overflow_out;
   logic                   Underflow_out;

   modport slave (
      input  Clear_in, Data_in, WriteEn_in, ReadEn_in,
      output Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out, Level_out,
      output Overflow_out, Underflow_out
   );

   modport master (
      output Clear_in, Data_in, WriteEn_in, ReadEn_in,
      input  Full_out, AlmostFull_out, Data_out, Empty_out, AlmostEmpty_out, Level_out,
      input  Overflow_out, Underflow_out
   );
endinterface

// File: rtl/sync_level_fifo.sv
// Single-clock FIFO with registered level and threshold flags.
// Define SYNC_LEVEL_FIFO_ERRFLAGS_EN to build sticky overflow/underflow flags.
module sync_level_fifo #(
   parameter int unsigned DATA_WIDTH         = 8,
   parameter int unsigned ADDRESS_WIDTH      = 4,
   parameter int unsigned ALMOST_FULL_LEVEL  = (1 << ADDRESS_WIDTH) - 2,
   parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
   input  logic               Clk,
   input  logic               Rst_n,
   sync_level_fifo_if.slave   bus
);
   localparam int unsigned FIFO_DEPTH = 1 << ADDRESS_WIDTH;
   localparam int unsigned LVL_W      = ADDRESS_WIDTH + 1;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [ADDRESS_WIDTH:0] AF_LVL    = LVL_W'(ALMOST_FULL_LEVEL);
   localparam logic [ADDRESS_WIDTH:0] AE_LVL    = LVL_W'(ALMOST_EMPTY_LEVEL);

   logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRESS_WIDTH:0]   level_q, level_d;
   logic [DATA_WIDTH-1:0]    dout_q, dout_d;
   logic                     full_q, full_d;
   logic                     empty_q, empty_d;
   logic                     afull_q, afull_d;
   logic                     aempty_q, aempty_d;
   logic                     wr_acc, rd_acc;

   // Clear blocks both accepts; a write into a full FIFO only lands if a read frees a slot.
   always_comb begin
      rd_acc = bus.ReadEn_in & ~empty_q & ~bus.Clear_in;
      wr_acc = bus.WriteEn_in & (~full_q | rd_acc) & ~bus.Clear_in;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      dout_d   = dout_q;
      if (bus.Clear_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
         end
         level_d = level_q + {{ADDRESS_WIDTH{1'b0}}, wr_acc} - {{ADDRESS_WIDTH{1'b0}}, rd_acc};
      end
      full_d   = (level_d == DEPTH_LVL);
      empty_d  = (level_d == '0);
      afull_d  = (level_d >= AF_LVL);
      aempty_d = (level_d <= AE_LVL);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   // Storage is deliberately unreset; reads are gated by the empty flag.
   always_ff @(posedge Clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= bus.Data_in;
      end
   end

   assign bus.Level_out       = level_q;
   assign bus.Data_out        = dout_q;
   assign bus.Full_out        = full_q;
   assign bus.Empty_out       = empty_q;
   assign bus.AlmostFull_out  = afull_q;
   assign bus.AlmostEmpty_out = aempty_q;

`ifdef SYNC_LEVEL_FIFO_ERRFLAGS_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | (bus.WriteEn_in & full_q & ~rd_acc);
      unf_d = unf_q | (bus.ReadEn_in & empty_q);
      if (bus.Clear_in) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.Overflow_out  = ovf_q;
   assign bus.Underflow_out = unf_q;
`else
   assign bus.Overflow_out  = 1'b0;
   assign bus.Underflow_out = 1'b0;
`endif
endmodule

// File: tb/tb_sync_level_fifo.sv
// Randomised bench for sync_level_fifo against a queue-based reference model.
module tb_sync_level_fifo;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFL   = 14;
   localparam int unsigned AEL   = 2;
`ifdef SYNC_LEVEL_FIFO_ERRFLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic Clk;
   logic Rst_n;

   sync_level_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   sync_level_fifo #(
      .DATA_WIDTH        (DW),
      .ADDRESS_WIDTH     (AW),
      .ALMOST_FULL_LEVEL (AFL),
      .ALMOST_EMPTY_LEVEL(AEL)
   ) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .bus  (bus)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   int unsigned n_vec;
   int unsigned n_err;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout;
   bit            m_ovf;
   bit            m_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = mq.size();
      check({tag, ".level"},  32'(bus.Level_out), 32'(n));
      check({tag, ".full"},   32'(bus.Full_out), 32'(n == DEPTH));
      check({tag, ".empty"},  32'(bus.Empty_out), 32'(n == 0));
      check({tag, ".afull"},  32'(bus.AlmostFull_out), 32'(n >= AFL));
      check({tag, ".aempty"}, 32'(bus.AlmostEmpty_out), 32'(n <= AEL));
      check({tag, ".dout"},   32'(bus.Data_out), 32'(m_dout));
      check({tag, ".ovf"},    32'(bus.Overflow_out), 32'(m_ovf & ERR_EN));
      check({tag, ".unf"},    32'(bus.Underflow_out), 32'(m_unf & ERR_EN));
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model with queue semantics, then compare.
   task automatic step(input bit clr, input bit we, input bit re, input logic [DW-1:0] din);
      int n;
      bit rd;
      bit wr;
      bus.Clear_in   = clr;
      bus.WriteEn_in = we;
      bus.ReadEn_in  = re;
      bus.Data_in    = din;
      @(posedge Clk);
      n = mq.size();
      if (clr) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         rd = re && (n > 0);
         wr = we && ((n < DEPTH) || rd);
         if (we && (n == DEPTH) && !rd) m_ovf = 1'b1;
         if (re && (n == 0)) m_unf = 1'b1;
         if (rd) m_dout = mq.pop_front();
         if (wr) mq.push_back(din);
      end
      #1;
      check_all("step");
   endtask

   task automatic async_reset();
      @(negedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      check("async_rst.level0", 32'(bus.Level_out), 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   initial begin
      int pw;
      int pr;
      n_vec = 0;
      n_err = 0;
      Rst_n = 1'b0;
      bus.Clear_in   = 1'b0;
      bus.WriteEn_in = 1'b0;
      bus.ReadEn_in  = 1'b0;
      bus.Data_in    = '0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge Clk);
      Rst_n = 1'b1;

      // Fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b0, DW'(i));
         if (i == 12) check("fill.af_at13", 32'(bus.AlmostFull_out), 32'd0);
         if (i == 13) check("fill.af_at14", 32'(bus.AlmostFull_out), 32'd1);
      end
      check("fill.full", 32'(bus.Full_out), 32'd1);
      check("fill.level", 32'(bus.Level_out), 32'd16);

      // Drain, expecting the written order
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         check("drain.data", 32'(bus.Data_out), 32'(i));
      end
      check("drain.empty", 32'(bus.Empty_out), 32'd1);

      // Full with simultaneous read and write
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 16));
      step(1'b0, 1'b1, 1'b1, 8'hAA);
      check("full_rw.level", 32'(bus.Level_out), 32'd16);
      check("full_rw.full", 32'(bus.Full_out), 32'd1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, '0);
      check("full_rw.aa_last", 32'(bus.Data_out), 32'hAA);

      // Empty with simultaneous read and write
      step(1'b0, 1'b1, 1'b1, 8'h55);
      check("empty_rw.level", 32'(bus.Level_out), 32'd1);
      check("empty_rw.dout_held", 32'(bus.Data_out), 32'hAA);
      step(1'b0, 1'b0, 1'b1, '0);
      check("empty_rw.read55", 32'(bus.Data_out), 32'h55);

      // Clear with a concurrent write, then sticky error flags
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 8'h40));
      step(1'b1, 1'b1, 1'b0, 8'hEE);
      check("clear.level", 32'(bus.Level_out), 32'd0);
      check("clear.empty", 32'(bus.Empty_out), 32'd1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
      step(1'b0, 1'b1, 1'b0, 8'h77);
      check("ovf.set", 32'(bus.Overflow_out), 32'(ERR_EN));
      step(1'b0, 1'b0, 1'b0, '0);
      check("ovf.sticky", 32'(bus.Overflow_out), 32'(ERR_EN));
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      check("unf.set", 32'(bus.Underflow_out), 32'(ERR_EN));
      step(1'b1, 1'b0, 1'b0, '0);
      check("unf.cleared", 32'(bus.Underflow_out), 32'd0);

      // Asynchronous reset with 7 words stored
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 8'h60));
      async_reset();
      step(1'b0, 1'b0, 1'b1, '0);

      // Random traffic with phase-varying bias so both ends get exercised
      pw = 50;
      pr = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) begin
            pw = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
         end
         if (i == 1500) async_reset();
         step(($urandom % 64) == 0,
              int'($urandom_range(0, 99)) < pw,
              int'($urandom_range(0, 99)) < pr,
              DW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
